spi_resp: RTL



---
 rtl/spi_resp_if.sv | 24 ++
 rtl/spi_resp.sv | 111 +++++++++++
 2 files changed

// File: rtl/spi_resp_if.sv
// Bundles the SPI pins and the parallel word side of the responder.
// MISO is kept out of this bundle because it is a tri-stated pin.
interface spi_resp_if #(
    parameter int WIDTH = 16
) ();
    logic             SS_n;
    logic             SCLK;
    logic             MOSI;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             rdy;
    logic             frm_err;
    logic             busy;

    modport slave (
        input  SS_n, SCLK, MOSI, tx_data,
        output rx_data, rdy, frm_err, busy
    );

    modport master (
        output SS_n, SCLK, MOSI, tx_data,
        input  rx_data, rdy, frm_err, busy
    );
endinterface

// File: rtl/spi_resp.sv
// Mode-3 SPI responder: shifts MOSI in on SCLK rise, returns the word loaded at frame start.
// MISO moves SYNC_STAGES+1 clk after each SCLK rise; no backpressure, the master owns the pace.
module spi_resp #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_resp_if.slave  bus,
    output wire        MISO
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [4:0] WIDTH_C = 5'(WIDTH);

    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   ss_hist_q, sclk_hist_q;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise;

    state_t                 state_q;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       rx_data_q;
    logic                   rdy_q, frm_err_q, busy_q;

    // Synchronizers idle at 1 so a released bus never looks like an edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '1;
            ss_hist_q   <= 1'b1;
            sclk_hist_q <= 1'b1;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
            ss_hist_q   <= ss_s;
            sclk_hist_q <= sclk_s;
        end
    end

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall   = ss_hist_q & ~ss_s;
    assign ss_rise   = ~ss_hist_q & ss_s;
    assign sclk_rise = ~sclk_hist_q & sclk_s;

    // The end-of-frame count check sees a same-cycle final SCLK rise.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (sclk_rise) begin
            shift_d = {shift_q[WIDTH-2:0], mosi_s};
            cnt_d   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q <= SHIFT;
                        shift_q <= bus.tx_data;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_d;
                    if (ss_rise) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (cnt_d == WIDTH_C) begin
                            rx_data_q <= shift_d;
                            rdy_q     <= 1'b1;
                        end else begin
                            frm_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Raw SS_n gates the driver so the bus is released without synchronizer delay.
    assign MISO = bus.SS_n ? 1'bz : shift_q[WIDTH-1];

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;
    assign bus.busy    = busy_q;
endmodule
